value_sccb_writer: RTL and testbench

Transmit side for the push-button value path in the OV5640 pipeline. Watches the debounced 11-bit user value and, after it has been stable for a settle time, writes it to one OV5640 register over a bit-banged SCCB 3-phase write. Keeps the camera register in step with the button-adjusted setting without CPU involvement.

---
 rtl/sccb_pkg.sv | 30 +++
 rtl/sccb_tick_gen.sv | 26 ++
 rtl/value_sccb_writer.sv | 192 +++++++++++++++++++
 tb/tb_value_sccb_writer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared state, frame and phase definitions for the SCCB value writer
package sccb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_BIT,
        S_STOP,
        S_GAP
    } state_t;

    localparam logic [7:0] OV5640_WR_ID = 8'h78;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int FRAME_BITS = 36;

    // Ninth bit of each 9-bit phase is the ack slot.
    localparam logic [FRAME_BITS-1:0] ACK_SLOTS = {4{9'b0_0000_0001}};

    // Values above one byte saturate to 0xFF.
    function automatic logic [7:0] data_byte(input logic [10:0] v);
        return (v > 11'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// rtl/sccb_tick_gen.sv - free-running divider producing a one-cycle tick every DIV clocks
module sccb_tick_gen #(
    parameter int DIV = 125
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == W'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == W'(DIV - 1));

endmodule

// File: rtl/value_sccb_writer.sv
// rtl/value_sccb_writer.sv - writes the settled user value to one OV5640 register over SCCB
// Optional NACK detection and automatic retry when SCCB_ACK_CHECK_EN is defined.
module value_sccb_writer
    import sccb_pkg::*;
#(
    parameter int          DIV      = 125,
    parameter int          HOLD     = 200_000,
    parameter logic [7:0]  DEV_ID   = OV5640_WR_ID,
    parameter logic [15:0] REG_ADDR = 16'h5587
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] value,
    input  logic        sio_d_in,
    output logic        sio_c,
    output logic        sio_d_out,
    output logic        sio_d_oe,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  last_data
);

    localparam int CW = $clog2(HOLD + 1);

    logic                  tick;
    state_t                state;
    logic [1:0]            q;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] tx_sh;
    logic [FRAME_BITS-1:0] ack_sh;
    logic [7:0]            data_lat;
    logic                  sent_valid;
    logic                  nack_seen;
    logic [CW-1:0]         settle_cnt;
    logic [10:0]           prev_value;
    logic [7:0]            cur_byte;
    logic                  hold_met;
    logic                  nack_now;

    sccb_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign cur_byte = data_byte(value);
    assign hold_met = (settle_cnt == CW'(HOLD)) && (value == prev_value);

`ifdef SCCB_ACK_CHECK_EN
    assign nack_now = ack_sh[FRAME_BITS-1] & sio_d_in;
`else
    logic unused_sio_d_in;
    assign unused_sio_d_in = sio_d_in;
    assign nack_now        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            q          <= Q0;
            bit_cnt    <= '0;
            tx_sh      <= '0;
            ack_sh     <= '0;
            data_lat   <= '0;
            sent_valid <= 1'b0;
            nack_seen  <= 1'b0;
            settle_cnt <= '0;
            prev_value <= '0;
            sio_c      <= 1'b1;
            sio_d_out  <= 1'b1;
            sio_d_oe   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            last_data  <= '0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            prev_value <= value;

            // Settle timing runs every clock; state moves only on ticks.
            if (state == S_SETTLE) begin
                if (value != prev_value) begin
                    settle_cnt <= '0;
                end else if (settle_cnt != CW'(HOLD)) begin
                    settle_cnt <= settle_cnt + CW'(1);
                end
            end

            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (!sent_valid || cur_byte != last_data) begin
                            state      <= S_SETTLE;
                            settle_cnt <= '0;
                        end
                    end

                    S_SETTLE: begin
                        if (sent_valid && cur_byte == last_data) begin
                            state <= S_IDLE;
                        end else if (hold_met) begin
                            state     <= S_START;
                            q         <= Q0;
                            data_lat  <= cur_byte;
                            tx_sh     <= {DEV_ID, 1'b1, REG_ADDR[15:8], 1'b1,
                                          REG_ADDR[7:0], 1'b1, cur_byte, 1'b1};
                            ack_sh    <= ACK_SLOTS;
                            nack_seen <= 1'b0;
                            busy      <= 1'b1;
                            sio_c     <= 1'b1;
                            sio_d_out <= 1'b1;
                            sio_d_oe  <= 1'b1;
                        end
                    end

                    S_START: begin
                        q <= q + 2'd1;
                        case (q)
                            Q1: sio_d_out <= 1'b0;
                            Q2: sio_c <= 1'b0;
                            Q3: begin
                                state     <= S_BIT;
                                bit_cnt   <= '0;
                                sio_d_oe  <= !ack_sh[FRAME_BITS-1];
                                sio_d_out <= tx_sh[FRAME_BITS-1];
                            end
                            default: ;
                        endcase
                    end

                    S_BIT: begin
                        q <= q + 2'd1;
                        case (q)
                            Q1: sio_c <= 1'b1;
                            Q3: begin
                                sio_c <= 1'b0;
                                if (nack_now || bit_cnt == 6'(FRAME_BITS - 1)) begin
                                    state     <= S_STOP;
                                    nack_seen <= nack_now;
                                    sio_d_oe  <= 1'b1;
                                    sio_d_out <= 1'b0;
                                end else begin
                                    bit_cnt   <= bit_cnt + 6'd1;
                                    tx_sh     <= tx_sh << 1;
                                    ack_sh    <= ack_sh << 1;
                                    sio_d_oe  <= !ack_sh[FRAME_BITS-2];
                                    sio_d_out <= tx_sh[FRAME_BITS-2];
                                end
                            end
                            default: ;
                        endcase
                    end

                    S_STOP: begin
                        q <= q + 2'd1;
                        case (q)
                            Q0: sio_c <= 1'b1;
                            Q1: begin
                                sio_d_oe  <= 1'b0;
                                sio_d_out <= 1'b1;
                            end
                            Q3: begin
                                state <= S_GAP;
                                busy  <= 1'b0;
                                if (nack_seen) begin
                                    err <= 1'b1;
                                end else begin
                                    done       <= 1'b1;
                                    last_data  <= data_lat;
                                    sent_valid <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end

                    S_GAP: begin
                        q <= q + 2'd1;
                        if (q == Q3) begin
                            state <= S_IDLE;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_value_sccb_writer.sv
// tb/tb_value_sccb_writer.sv - self-checking bench for value_sccb_writer with a wire-level SCCB monitor
`timescale 1ns/1ps
module tb_value_sccb_writer;

    localparam int DIV       = 4;
    localparam int HOLD      = 16;
    localparam int FRAME_CYC = 152 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] value = '0;
    logic        sio_d_in = 1'b0;
    logic        sio_c, sio_d_out, sio_d_oe, busy, done, err;
    logic [7:0]  last_data;

    value_sccb_writer #(
        .DIV(DIV), .HOLD(HOLD), .DEV_ID(8'h78), .REG_ADDR(16'h5587)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .sio_d_in(sio_d_in),
        .sio_c(sio_c), .sio_d_out(sio_d_out), .sio_d_oe(sio_d_oe),
        .busy(busy), .done(done), .err(err), .last_data(last_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] bits;
        int          nbits;
    } frame_t;

    typedef struct {
        logic [10:0] value;
        logic        want_frame;
        logic [7:0]  data;
    } vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    frame_t     frames[$];
    frame_t     mon_f;
    int         starts = 0, dones = 0, errs = 0;
    int         busy_run = 0, last_busy_len = 0;
    logic       prev_c = 1'b1, prev_line = 1'b1, in_frame = 1'b0;
    logic [36:0] cap = '0;
    int         rises = 0;
    logic       nack_arm = 1'b0;
    logic [7:0] model_last = 8'h00;
    logic       model_valid = 1'b0;
    logic       line;

    assign line = sio_d_oe ? sio_d_out : 1'b1;

    function automatic logic [7:0] ref_byte(input logic [10:0] v);
        return (v >= 11'd256) ? 8'hFF : v[7:0];
    endfunction

    task automatic check(input string name, input string what, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s/%s: got %0h, expected %0h", name, what, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s/%s: timed out waiting for the DUT", name, what);
    endtask

    // Bus monitor: decodes START/STOP and bits at SIO_C rising edges.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            rises    = 0;
        end else if (sio_c && prev_c && prev_line && !line) begin
            in_frame = 1'b1;
            rises    = 0;
            cap      = '0;
            starts++;
        end else if (sio_c && prev_c && !prev_line && line && in_frame) begin
            in_frame    = 1'b0;
            mon_f.bits  = cap[36:1];
            mon_f.nbits = rises - 1;
            frames.push_back(mon_f);
        end else if (sio_c && !prev_c && in_frame) begin
            cap = {cap[35:0], line};
            rises++;
        end
        prev_c    = sio_c;
        prev_line = line;
        sio_d_in  = nack_arm && in_frame && (rises == 18);
        if (done) dones++;
        if (err) errs++;
        if (done || err) begin
            vectors++;
            if ((done && err) || busy) begin
                miscompares++;
                $display("FAIL pulse_excl: done=%0b err=%0b busy=%0b, expected a lone pulse with busy=0", done, err, busy);
            end
        end
        if (busy) busy_run++;
        else if (busy_run > 0) begin
            last_busy_len = busy_run;
            busy_run      = 0;
        end
    end

    task automatic wait_not_busy();
        int t = 0;
        while (busy && t < 2000) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_busy(input string name, output logic ok);
        int t = 0;
        while (!busy && t < 2000) begin @(negedge clk); t++; end
        ok = busy;
        if (!ok) timeout_fail(name, "busy_rise");
    endtask

    task automatic expect_frame(input string name, input logic [7:0] d);
        int     t = 0;
        int     d0 = dones;
        frame_t f;
        logic [35:0] want;
        while (frames.size() == 0 && t < 3000) begin @(negedge clk); t++; end
        if (frames.size() == 0) begin
            timeout_fail(name, "frame");
            return;
        end
        f    = frames.pop_front();
        want = {8'h78, 1'b1, 8'h55, 1'b1, 8'h87, 1'b1, d, 1'b1};
        check(name, "bits", f.bits, want);
        check(name, "nbits", f.nbits, 36);
        wait_not_busy();
        check(name, "done_count", dones - d0, 1);
        check(name, "last_data", last_data, d);
        check(name, "busy_len", last_busy_len, FRAME_CYC);
        model_last  = d;
        model_valid = 1'b1;
        repeat (6 * DIV) @(negedge clk);
    endtask

    task automatic expect_none(input string name, input int cycles);
        int s0 = starts;
        repeat (cycles) @(negedge clk);
        check(name, "starts", starts - s0, 0);
        check(name, "last_data", last_data, model_last);
    endtask

    vec_t tbl[8];

    initial begin
        logic [10:0] v;
        logic [7:0]  e;
        logic        ok;
        int          s0, d0, e0;
        frame_t      f;

        tbl[0] = '{11'd100,  1'b1, 8'h64};
        tbl[1] = '{11'd300,  1'b1, 8'hFF};
        tbl[2] = '{11'd255,  1'b0, 8'hFF};
        tbl[3] = '{11'd2047, 1'b0, 8'hFF};
        tbl[4] = '{11'd254,  1'b1, 8'hFE};
        tbl[5] = '{11'd254,  1'b0, 8'hFE};
        tbl[6] = '{11'd0,    1'b1, 8'h00};
        tbl[7] = '{11'd1023, 1'b1, 8'hFF};

        repeat (3) @(negedge clk);
        check("reset", "sio_c", sio_c, 1);
        check("reset", "sio_d_out", sio_d_out, 1);
        check("reset", "sio_d_oe", sio_d_oe, 0);
        check("reset", "busy", busy, 0);
        check("reset", "done", done, 0);
        check("reset", "err", err, 0);
        check("reset", "last_data", last_data, 0);
        rst = 1'b0;

        expect_frame("first_after_reset", 8'h00);

        value = 11'd80;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            value = tbl[i].value;
            if (tbl[i].want_frame) expect_frame("table", tbl[i].data);
            else expect_none("table_same", 400);
        end

        s0 = starts;
        for (int i = 0; i < 20; i++) begin
            value = (i % 2 == 0) ? 11'd50 : 11'd60;
            repeat (10) @(negedge clk);
        end
        check("toggle", "starts", starts - s0, 0);
        value = 11'd120;
        expect_frame("toggle_settled", 8'h78);
        expect_none("toggle_once", 500);

        value = 11'd170;
        wait_busy("midframe", ok);
        repeat (100) @(negedge clk);
        value = 11'd90;
        expect_frame("midframe_first", 8'hAA);
        expect_frame("midframe_second", 8'h5A);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: v = model_valid ? ((model_last == 8'hFF) ? 11'($urandom_range(256, 2047)) : {3'b000, model_last}) : 11'd0;
                1: v = 11'($urandom_range(0, 2047));
                default: v = 11'($urandom_range(0, 255));
            endcase
            e = ref_byte(v);
            value = v;
            if (!model_valid || e != model_last) expect_frame("random", e);
            else expect_none("random_same", 300);
        end

        v = {3'b000, model_last ^ 8'h3C};
        e = ref_byte(v);
`ifdef SCCB_ACK_CHECK_EN
        d0 = dones;
        e0 = errs;
        nack_arm = 1'b1;
        value = v;
        s0 = 0;
        while (frames.size() == 0 && s0 < 3000) begin @(negedge clk); s0++; end
        nack_arm = 1'b0;
        if (frames.size() == 0) begin
            timeout_fail("nack", "frame");
        end else begin
            f = frames.pop_front();
            check("nack", "nbits", f.nbits, 18);
            check("nack", "bits", f.bits[17:0], {8'h78, 1'b1, 8'h55, 1'b1});
        end
        wait_not_busy();
        check("nack", "err_count", errs - e0, 1);
        check("nack", "done_count", dones - d0, 0);
        check("nack", "last_data", last_data, model_last);
`else
        value = v;
`endif
        wait_busy("reset_mid", ok);
        if (ok) begin
            repeat (150) @(negedge clk);
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check("reset_mid", "sio_c", sio_c, 1);
            check("reset_mid", "sio_d_oe", sio_d_oe, 0);
            check("reset_mid", "sio_d_out", sio_d_out, 1);
            check("reset_mid", "busy", busy, 0);
            check("reset_mid", "last_data", last_data, 0);
            @(negedge clk);
            rst = 1'b0;
            frames.delete();
            model_valid = 1'b0;
            model_last  = 8'h00;
            expect_frame("after_reset_mid", e);
        end

`ifndef SCCB_ACK_CHECK_EN
        check("no_ack", "err_count", errs, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900_000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
